// File: rtl/seg_ripple_adder_if.sv
// Handshake and operand/result bundle for seg_ripple_adder.
// master drives operations and accepts results; slave is the adder.
interface seg_ripple_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/seg_ripple_adder.sv
// Multi-cycle ripple adder/subtractor: one SEG-bit slice per clock, LSB first,
// linked through a single carry register. Valid/ready on both sides.
module seg_ripple_adder #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  seg_ripple_adder_if.slave  bus
);
  localparam int NSEG = WIDTH / SEG;
  localparam int CW   = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSEG - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_out_valid;

  logic [SEG-1:0]   w_a_seg;
  logic [SEG-1:0]   w_b_seg;
  logic [SEG:0]     w_seg;
  logic             w_cmsb;

  // Segment selection by counter; constant slice bounds keep every SEG legal.
  always_comb begin
    w_a_seg = '0;
    w_b_seg = '0;
    for (int k = 0; k < NSEG; k++) begin
      if (r_cnt == CW'(k)) begin
        w_a_seg = r_a[k*SEG +: SEG];
        w_b_seg = r_b[k*SEG +: SEG];
      end
    end
    w_seg  = {1'b0, w_a_seg} + {1'b0, w_b_seg} + {{SEG{1'b0}}, r_carry};
    // Carry into a slice's top bit recovered from the sum bit itself.
    w_cmsb = w_seg[SEG-1] ^ w_a_seg[SEG-1] ^ w_b_seg[SEG-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_a     <= bus.a;
            r_b     <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.sub | bus.cin;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          for (int k = 0; k < NSEG; k++) begin
            if (r_cnt == CW'(k)) r_sum[k*SEG +: SEG] <= w_seg[SEG-1:0];
          end
          r_carry <= w_seg[SEG];
          if (r_cnt == LAST) begin
            r_cout      <= w_seg[SEG];
            r_ovf       <= w_seg[SEG] ^ w_cmsb;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;
endmodule

// File: tb/tb_seg_ripple_adder.sv
// Scoreboard bench for seg_ripple_adder: directed cases on 16/4, random
// sweeps on 16/1, 16/16 and 32/8 against a full-width arithmetic model.
module tb_seg_ripple_adder;
  typedef struct {
    logic [31:0] sum;
    logic        c;
    logic        o;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t q[4][$];
  logic [3:0] pv = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seg_ripple_adder_if #(.WIDTH(16)) if0 ();
  seg_ripple_adder_if #(.WIDTH(16)) if1 ();
  seg_ripple_adder_if #(.WIDTH(16)) if2 ();
  seg_ripple_adder_if #(.WIDTH(32)) if3 ();

  seg_ripple_adder #(.WIDTH(16), .SEG(4))  u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  seg_ripple_adder #(.WIDTH(16), .SEG(1))  u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  seg_ripple_adder #(.WIDTH(16), .SEG(16)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  seg_ripple_adder #(.WIDTH(32), .SEG(8))  u3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Returns {ovf, cout, sum[31:0]} for a w-bit operation.
  function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic ci, input logic sb);
    logic [63:0] mask, hm, bb, full, low;
    logic        c0, co, cm;
    mask = (64'd1 << w) - 64'd1;
    hm   = (64'd1 << (w - 1)) - 64'd1;
    bb   = (sb ? ~{32'd0, b} : {32'd0, b}) & mask;
    c0   = sb | ci;
    full = ({32'd0, a} & mask) + bb + 64'(c0);
    low  = ({32'd0, a} & hm) + (bb & hm) + 64'(c0);
    co   = full[w];
    cm   = low[w-1];
    return {co ^ cm, co, full[31:0] & mask[31:0]};
  endfunction

  task automatic push(input int idx, input logic [33:0] m, input int acc);
    exp_t e;
    e.sum = m[31:0];
    e.c   = m[32];
    e.o   = m[33];
    e.acc = acc;
    q[idx].push_back(e);
  endtask

  task automatic mon(input int idx, input logic [31:0] s, input logic c, input logic o, input int nseg);
    exp_t e;
    if (q[idx].size() == 0) begin
      check_eq($sformatf("u%0d_spurious_valid", idx), 64'd1, 64'd0);
    end else begin
      e = q[idx].pop_front();
      check_eq($sformatf("u%0d_sum", idx), 64'(s), 64'(e.sum));
      check_eq($sformatf("u%0d_cout", idx), 64'(c), 64'(e.c));
      check_eq($sformatf("u%0d_ovf", idx), 64'(o), 64'(e.o));
      check_eq($sformatf("u%0d_latency", idx), 64'(cyc - e.acc), 64'(nseg));
    end
  endtask

  always @(negedge clk) begin
    if (if0.out_valid === 1'b1 && pv[0] === 1'b0) mon(0, 32'(if0.sum), if0.cout, if0.ovf, 4);
    if (if1.out_valid === 1'b1 && pv[1] === 1'b0) mon(1, 32'(if1.sum), if1.cout, if1.ovf, 16);
    if (if2.out_valid === 1'b1 && pv[2] === 1'b0) mon(2, 32'(if2.sum), if2.cout, if2.ovf, 1);
    if (if3.out_valid === 1'b1 && pv[3] === 1'b0) mon(3, if3.sum, if3.cout, if3.ovf, 4);
    pv <= {if3.out_valid, if2.out_valid, if1.out_valid, if0.out_valid};
  end

  task automatic send0(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sb,
                       input logic [15:0] es, input logic ec, input logic eo);
    int n;
    n = 0;
    @(negedge clk);
    while (if0.in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("u0_accept_wait", 64'(n < 100), 64'd1);
    if0.a = a; if0.b = b; if0.cin = ci; if0.sub = sb; if0.in_valid = 1'b1;
    push(0, {eo, ec, 16'd0, es}, cyc + 1);
    @(negedge clk);
    if0.in_valid = 1'b0; if0.a = 16'hFFFF; if0.b = 16'hFFFF; if0.cin = 1'b1; if0.sub = 1'b0;
  endtask

  task automatic drain(input int idx);
    int n;
    n = 0;
    while (q[idx].size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq($sformatf("u%0d_drain", idx), 64'(q[idx].size()), 64'd0);
    @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    if0.in_valid = 0; if0.a = '0; if0.b = '0; if0.cin = 0; if0.sub = 0; if0.out_ready = 1;
    if1.in_valid = 0; if1.a = '0; if1.b = '0; if1.cin = 0; if1.sub = 0; if1.out_ready = 1;
    if2.in_valid = 0; if2.a = '0; if2.b = '0; if2.cin = 0; if2.sub = 0; if2.out_ready = 1;
    if3.in_valid = 0; if3.a = '0; if3.b = '0; if3.cin = 0; if3.sub = 0; if3.out_ready = 1;
    repeat (2) @(negedge clk);
    check_eq("rst_out_valid", 64'(if0.out_valid), 64'd0);
    check_eq("rst_sum", 64'(if0.sum), 64'd0);
    check_eq("rst_cout", 64'(if0.cout), 64'd0);
    check_eq("rst_ovf", 64'(if0.ovf), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_in_ready", 64'(if0.in_ready), 64'd1);

    // Wrap-around add with in_ready low while running
    send0(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check_eq("run_in_ready", 64'(if0.in_ready), 64'd0);
      @(negedge clk);
    end
    drain(0);

    send0(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    send0(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
    send0(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    send0(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    send0(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    send0(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    drain(0);

    // Backpressure: result must hold, new operands must be ignored
    if0.out_ready = 1'b0;
    send0(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);
    n = 0;
    while (if0.out_valid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("bp_valid_seen", 64'(if0.out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      if0.in_valid = 1'b1; if0.a = 16'hAAAA; if0.b = 16'h5555;
      check_eq("bp_sum", 64'(if0.sum), 64'h3333);
      check_eq("bp_cout", 64'(if0.cout), 64'd0);
      check_eq("bp_ovf", 64'(if0.ovf), 64'd0);
      check_eq("bp_in_ready", 64'(if0.in_ready), 64'd0);
      check_eq("bp_out_valid", 64'(if0.out_valid), 64'd1);
      @(negedge clk);
    end
    if0.in_valid = 1'b0;
    if0.out_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_release_valid", 64'(if0.out_valid), 64'd0);
    check_eq("bp_release_ready", 64'(if0.in_ready), 64'd1);
    repeat (3) @(negedge clk);

    // Reset after two RUN cycles aborts the operation
    send0(16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0);
    q[0].delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("mid_rst_valid", 64'(if0.out_valid), 64'd0);
    check_eq("mid_rst_sum", 64'(if0.sum), 64'd0);
    check_eq("mid_rst_ready", 64'(if0.in_ready), 64'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("mid_rst_no_valid", 64'(if0.out_valid), 64'd0);
    end
    send0(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    drain(0);

    // Random sweeps on the other configurations, run concurrently
    fork
      begin : sw1
        logic [31:0] ra, rb;
        logic rc, rs;
        int m;
        for (int i = 0; i < 1000; i++) begin
          ra = $urandom; rb = $urandom;
          rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
          if1.a = ra[15:0]; if1.b = rb[15:0]; if1.cin = rc; if1.sub = rs; if1.in_valid = 1'b1;
          m = 0;
          while (if1.in_ready !== 1'b1 && m < 100) begin
            @(negedge clk);
            m++;
          end
          if (m >= 100) check_eq("u1_accept_timeout", 64'(m), 64'd0);
          push(1, model(16, {16'd0, ra[15:0]}, {16'd0, rb[15:0]}, rc, rs), cyc + 1);
          @(negedge clk);
        end
        if1.in_valid = 1'b0;
      end
      begin : sw2
        logic [31:0] ra, rb;
        logic rc, rs;
        int m;
        for (int i = 0; i < 1000; i++) begin
          ra = $urandom; rb = $urandom;
          rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
          if2.a = ra[15:0]; if2.b = rb[15:0]; if2.cin = rc; if2.sub = rs; if2.in_valid = 1'b1;
          m = 0;
          while (if2.in_ready !== 1'b1 && m < 100) begin
            @(negedge clk);
            m++;
          end
          if (m >= 100) check_eq("u2_accept_timeout", 64'(m), 64'd0);
          push(2, model(16, {16'd0, ra[15:0]}, {16'd0, rb[15:0]}, rc, rs), cyc + 1);
          @(negedge clk);
        end
        if2.in_valid = 1'b0;
      end
      begin : sw3
        logic [31:0] ra, rb;
        logic rc, rs;
        int m;
        for (int i = 0; i < 1000; i++) begin
          ra = $urandom; rb = $urandom;
          rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
          if3.a = ra; if3.b = rb; if3.cin = rc; if3.sub = rs; if3.in_valid = 1'b1;
          m = 0;
          while (if3.in_ready !== 1'b1 && m < 100) begin
            @(negedge clk);
            m++;
          end
          if (m >= 100) check_eq("u3_accept_timeout", 64'(m), 64'd0);
          push(3, model(32, ra, rb, rc, rs), cyc + 1);
          @(negedge clk);
        end
        if3.in_valid = 1'b0;
      end
    join
    drain(1);
    drain(2);
    drain(3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
